// File: rtl/mfcc_pkg.sv
// Shared constants and types for the MFCC back-end (cepstral delta stage).
package mfcc_pkg;
  localparam int NUM_CEPS    = 12;
  localparam int CEPS_WIDTH  = 16;
  localparam int DELTA_WIDTH = 16;
  localparam int HIST_FRAMES = 6;
  localparam int WIN_FRAMES  = 5;
  localparam int RECIP_Q15   = 3277;
  localparam int PTR_W       = $clog2(NUM_CEPS);
  localparam int SLOT_W      = $clog2(HIST_FRAMES);

  typedef logic signed [CEPS_WIDTH-1:0] ceps_t;

  typedef enum logic {IDLE, COMPUTE} delta_state_t;

  // Ring-buffer slot that lies 'back' frames behind slot s.
  function automatic logic [SLOT_W-1:0] slot_back(input logic [SLOT_W-1:0] s, input int back);
    int idx;
    idx = (int'(s) + HIST_FRAMES - back) % HIST_FRAMES;
    return SLOT_W'(idx);
  endfunction
endpackage

// File: rtl/delta_arith.sv
// Combinational 5-tap regression delta: ((c+1 - c-1) + 2(c+2 - c-2)) / 10,
// done as a Q15 multiply with round-half-up and saturation to the output width.
module delta_arith
  import mfcc_pkg::*;
#(
  parameter int IN_W  = CEPS_WIDTH,
  parameter int OUT_W = DELTA_WIDTH,
  parameter int RECIP = RECIP_Q15
) (
  input  logic signed [IN_W-1:0]  cp2_i,
  input  logic signed [IN_W-1:0]  cp1_i,
  input  logic signed [IN_W-1:0]  cm1_i,
  input  logic signed [IN_W-1:0]  cm2_i,
  output logic signed [OUT_W-1:0] delta_o
);
  localparam int NUM_W  = IN_W + 3;
  localparam int PROD_W = NUM_W + 17;
  localparam int RND_W  = PROD_W - 15;
  localparam logic signed [PROD_W-1:0] HALF    = PROD_W'(1 << 14);
  localparam logic signed [RND_W-1:0]  OUT_MAX = RND_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [RND_W-1:0]  OUT_MIN = RND_W'(-(1 << (OUT_W - 1)));

  function automatic logic signed [RND_W-1:0] round_q15(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] t;
    t = (p + HALF) >>> 15;
    return RND_W'(t);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [RND_W-1:0] v);
    if (v > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction

  logic signed [NUM_W-1:0]  d1, d2, num;
  logic signed [PROD_W-1:0] prod;

  // Regression numerator, Q15 scale, round and clamp.
  always_comb begin
    d1      = NUM_W'(cp1_i) - NUM_W'(cm1_i);
    d2      = NUM_W'(cp2_i) - NUM_W'(cm2_i);
    num     = d1 + (d2 <<< 1);
    prod    = PROD_W'(num) * PROD_W'(RECIP);
    delta_o = sat_out(round_q15(prod));
  end
endmodule

// File: rtl/ceps_delta.sv
// Cepstral delta stage: 6-frame coefficient history, emits the centre-frame
// static value and its first-order delta for every coefficient of a frame.
module ceps_delta
  import mfcc_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [PTR_W-1:0]              frame_ptr_i,
  input  logic signed [CEPS_WIDTH-1:0]  ceps_in,
  input  logic                          start_i,
  output logic                          delta_valid_o,
  output logic [PTR_W-1:0]              delta_ptr_o,
  output logic signed [CEPS_WIDTH-1:0]  static_o,
  output logic signed [DELTA_WIDTH-1:0] delta_o,
  output logic                          delta_done_o,
  output logic                          busy_o,
  output logic                          overflow_o
);
  ceps_t                    hist_q [HIST_FRAMES][NUM_CEPS];
  logic [SLOT_W-1:0]        wr_slot_q;
  logic [2:0]               seen_q;
  delta_state_t             state_q, state_d;
  logic [PTR_W-1:0]         k_q, k_d;
  logic [SLOT_W-1:0]        base_q, base_d, pbase_q, pbase_d;
  logic                     pend_q, pend_d, ovf_q, ovf_d;
  logic                     req, last_k;
  ceps_t                    tap_p2, tap_p1, tap_0, tap_m1, tap_m2;
  logic signed [DELTA_WIDTH-1:0] delta_c;
  logic                     vld_p1_q, done_p2_q;
  logic [PTR_W-1:0]         ptr_p1_q;
  ceps_t                    static_p1_q;
  logic signed [DELTA_WIDTH-1:0] delta_p1_q;

  // A full 5-frame window exists once this start completes the fifth frame.
  assign req    = start_i && (seen_q >= 3'(WIN_FRAMES - 1));
  assign last_k = (k_q == PTR_W'(NUM_CEPS - 1));

  // History write port; out-of-range coefficient indices are dropped.
  always_ff @(posedge clk) begin
    if (in_valid && (frame_ptr_i < PTR_W'(NUM_CEPS)))
      hist_q[wr_slot_q][frame_ptr_i] <= ceps_in;
  end

  // Frame bookkeeping: advance write slot and count frames (saturating).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_slot_q <= '0;
      seen_q    <= '0;
    end else if (start_i) begin
      wr_slot_q <= (wr_slot_q == SLOT_W'(HIST_FRAMES - 1)) ? '0 : wr_slot_q + 1'b1;
      if (seen_q != 3'(WIN_FRAMES)) seen_q <= seen_q + 1'b1;
    end
  end

  // FSM and sequencing state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      base_q  <= '0;
      pbase_q <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      pbase_q <= pbase_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: one coefficient per COMPUTE cycle; one request may queue.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    pbase_d = pbase_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = COMPUTE;
          k_d     = '0;
          base_d  = wr_slot_q;
        end
      end
      COMPUTE: begin
        if (last_k) begin
          k_d = '0;
          if (pend_q) begin
            base_d = pbase_q;
            pend_d = 1'b0;
            if (req) ovf_d = 1'b1;
          end else if (req) begin
            base_d = wr_slot_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          k_d = k_q + 1'b1;
          if (req) begin
            if (pend_q) begin
              ovf_d = 1'b1;
            end else begin
              pend_d  = 1'b1;
              pbase_d = wr_slot_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tap_p2 = hist_q[slot_back(base_q, 0)][k_q];
  assign tap_p1 = hist_q[slot_back(base_q, 1)][k_q];
  assign tap_0  = hist_q[slot_back(base_q, 2)][k_q];
  assign tap_m1 = hist_q[slot_back(base_q, 3)][k_q];
  assign tap_m2 = hist_q[slot_back(base_q, 4)][k_q];

  delta_arith #(
    .IN_W  (CEPS_WIDTH),
    .OUT_W (DELTA_WIDTH),
    .RECIP (RECIP_Q15)
  ) u_arith (
    .cp2_i   (tap_p2),
    .cp1_i   (tap_p1),
    .cm1_i   (tap_m1),
    .cm2_i   (tap_m2),
    .delta_o (delta_c)
  );

  // Output register stage; data holds while no coefficient is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q    <= 1'b0;
      done_p2_q   <= 1'b0;
      ptr_p1_q    <= '0;
      static_p1_q <= '0;
      delta_p1_q  <= '0;
    end else begin
      vld_p1_q  <= (state_q == COMPUTE);
      done_p2_q <= vld_p1_q && (ptr_p1_q == PTR_W'(NUM_CEPS - 1));
      if (state_q == COMPUTE) begin
        ptr_p1_q    <= k_q;
        static_p1_q <= tap_0;
        delta_p1_q  <= delta_c;
      end
    end
  end

  assign delta_valid_o = vld_p1_q;
  assign delta_ptr_o   = ptr_p1_q;
  assign static_o      = static_p1_q;
  assign delta_o       = delta_p1_q;
  assign delta_done_o  = done_p2_q;
  assign busy_o        = (state_q == COMPUTE);
  assign overflow_o    = ovf_q;
endmodule

// File: tb/tb_ceps_delta.sv
// Directed bench for ceps_delta: latency, regression values, rounding,
// saturation-edge values, back-to-back frames, overflow and mid-compute reset.
module tb_ceps_delta;
  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [3:0]         frame_ptr_i;
  logic signed [15:0] ceps_in;
  logic               start_i;
  logic               delta_valid_o;
  logic [3:0]         delta_ptr_o;
  logic signed [15:0] static_o;
  logic signed [15:0] delta_o;
  logic               delta_done_o;
  logic               busy_o;
  logic               overflow_o;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int start_cyc;
  int q_ptr[$], q_st[$], q_dl[$], q_cyc[$], d_cyc[$];
  logic signed [15:0] fr [5][12];
  int exp_st [12];
  int exp_dl [12];

  ceps_delta dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .frame_ptr_i   (frame_ptr_i),
    .ceps_in       (ceps_in),
    .start_i       (start_i),
    .delta_valid_o (delta_valid_o),
    .delta_ptr_o   (delta_ptr_o),
    .static_o      (static_o),
    .delta_o       (delta_o),
    .delta_done_o  (delta_done_o),
    .busy_o        (busy_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (delta_valid_o) begin
      q_ptr.push_back(int'(delta_ptr_o));
      q_st.push_back(int'(static_o));
      q_dl.push_back(int'(delta_o));
      q_cyc.push_back(cyc);
    end
    if (delta_done_o) d_cyc.push_back(cyc);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clrq();
    q_ptr.delete(); q_st.delete(); q_dl.delete(); q_cyc.delete(); d_cyc.delete();
  endtask

  task automatic pulse_start();
    start_i   = 1'b1;
    start_cyc = cyc;
    step(1);
    start_i   = 1'b0;
  endtask

  task automatic write_row(input int row, input int nk);
    for (int k = 0; k < nk; k++) begin
      in_valid    = 1'b1;
      frame_ptr_i = 4'(k);
      ceps_in     = fr[row][k];
      step(1);
    end
    in_valid = 1'b0;
  endtask

  // Write one frame, close it, and let any triggered compute drain.
  task automatic push_frame(input int row);
    write_row(row, 12);
    pulse_start();
    step(16);
  endtask

  task automatic chk_block(input string tag);
    chk({tag, "_cnt"}, q_ptr.size(), 12);
    chk({tag, "_done"}, d_cyc.size(), 1);
    if (q_ptr.size() == 12) begin
      for (int k = 0; k < 12; k++) begin
        chk($sformatf("%s_ptr%0d", tag, k), q_ptr[k], k);
        chk($sformatf("%s_st%0d", tag, k), q_st[k], exp_st[k]);
        chk($sformatf("%s_dl%0d", tag, k), q_dl[k], exp_dl[k]);
      end
    end
  endtask

  task automatic load_ramp();
    for (int t = 0; t < 5; t++)
      for (int k = 0; k < 12; k++)
        fr[t][k] = 16'(100 * t + k);
    for (int k = 0; k < 12; k++) begin
      exp_st[k] = 200 + k;
      exp_dl[k] = 100;
    end
  endtask

  initial begin
    int bad;
    rst = 1'b1; in_valid = 1'b0; frame_ptr_i = '0; ceps_in = '0; start_i = 1'b0;
    start_cyc = 0;
    step(3);
    @(negedge clk);
    chk("rst_valid", int'(delta_valid_o), 0);
    chk("rst_done", int'(delta_done_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_ovf", int'(overflow_o), 0);
    chk("rst_static", int'(static_o), 0);
    chk("rst_delta", int'(delta_o), 0);
    rst = 1'b0;
    step(1);

    // Ramp: first three frames silent, fifth frame yields the block.
    load_ramp();
    for (int t = 0; t < 3; t++) push_frame(t);
    chk("warmup_no_valid", q_ptr.size(), 0);
    chk("warmup_no_done", d_cyc.size(), 0);
    push_frame(3);
    chk("frame4_no_valid", q_ptr.size(), 0);
    push_frame(4);
    chk_block("ramp");
    if (q_cyc.size() == 12 && d_cyc.size() == 1) begin
      chk("lat_first", q_cyc[0] - start_cyc, 2);
      chk("lat_last", q_cyc[11] - start_cyc, 13);
      chk("lat_done", d_cyc[0] - start_cyc, 14);
    end

    // Constant frames give zero delta.
    for (int t = 0; t < 5; t++)
      for (int k = 0; k < 12; k++)
        fr[t][k] = -16'sd7;
    for (int k = 0; k < 12; k++) begin
      exp_st[k] = -7;
      exp_dl[k] = 0;
    end
    for (int t = 0; t < 4; t++) push_frame(t);
    clrq();
    push_frame(4);
    chk_block("const");

    // Rounding / extreme window; rows 0..4 are t-2..t+2.
    // 3277/32768 sits slightly above 1/10, so +-131070 rounds to +-13108.
    for (int t = 0; t < 5; t++)
      for (int k = 0; k < 12; k++)
        fr[t][k] = '0;
    fr[3][0] = 16'sd1;      fr[4][0] = 16'sd2;                 // num=+5
    fr[3][1] = -16'sd1;     fr[4][1] = -16'sd2;                // num=-5
    fr[4][2] = 16'sd2;                                         // num=+4
    fr[4][3] = 16'sd32767;  fr[0][3] = -16'sd32768;            // num=+131070
    fr[4][4] = -16'sd32768; fr[0][4] = 16'sd32767;             // num=-131070
    fr[4][5] = -16'sd2;                                        // num=-4
    fr[4][6] = 16'sd3;                                         // num=+6
    fr[4][7] = -16'sd3;                                        // num=-6
    fr[2][8] = 16'sd9999;                                      // static only
    fr[2][9] = -16'sd12345;                                    // static only
    fr[4][10] = -16'sd1;                                       // num=-2
    fr[3][11] = 16'sd100;   fr[1][11] = -16'sd100;             // num=+200
    exp_dl = '{1, -1, 0, 13108, -13108, 0, 1, -1, 0, 0, 0, 20};
    for (int k = 0; k < 12; k++) exp_st[k] = int'(fr[2][k]);
    for (int t = 0; t < 4; t++) push_frame(t);
    clrq();
    push_frame(4);
    chk_block("round");

    // Back-to-back: next frame closes on the last compute cycle.
    clrq();
    write_row(0, 12);
    pulse_start();
    write_row(1, 11);
    in_valid = 1'b1; frame_ptr_i = 4'd11; ceps_in = fr[1][11]; start_i = 1'b1;
    step(1);
    in_valid = 1'b0; start_i = 1'b0;
    step(30);
    chk("b2b_cnt", q_ptr.size(), 24);
    chk("b2b_done", d_cyc.size(), 2);
    chk("b2b_ovf", int'(overflow_o), 0);
    if (q_ptr.size() == 24) begin
      bad = 0;
      for (int i = 0; i < 24; i++)
        if (q_cyc[i] != q_cyc[0] + i || q_ptr[i] != i % 12) bad++;
      chk("b2b_contig", bad, 0);
      chk("b2b_lat", q_cyc[0] - start_cyc, 2);
    end

    // Overflow: one request queues, the next is dropped.
    clrq();
    pulse_start();
    step(2);
    pulse_start();
    step(1);
    chk("pend_no_ovf", int'(overflow_o), 0);
    pulse_start();
    @(negedge clk);
    chk("ovf_set", int'(overflow_o), 1);
    step(40);
    chk("ovf_sticky", int'(overflow_o), 1);
    chk("ovf_blocks", q_ptr.size(), 24);
    chk("ovf_idle", int'(busy_o), 0);

    // Reset at k=5 of a compute.
    pulse_start();
    step(5);
    chk("mid_busy", int'(busy_o), 1);
    rst = 1'b1;
    step(1);
    @(negedge clk);
    chk("mrst_valid", int'(delta_valid_o), 0);
    chk("mrst_done", int'(delta_done_o), 0);
    chk("mrst_busy", int'(busy_o), 0);
    chk("mrst_ovf", int'(overflow_o), 0);
    chk("mrst_static", int'(static_o), 0);
    chk("mrst_delta", int'(delta_o), 0);
    chk("mrst_ptr", int'(delta_ptr_o), 0);
    rst = 1'b0;
    step(1);
    clrq();
    load_ramp();
    for (int t = 0; t < 4; t++) push_frame(t);
    chk("mrst_4fr_valid", q_ptr.size(), 0);
    chk("mrst_4fr_done", d_cyc.size(), 0);
    push_frame(4);
    chk_block("mrst_ramp");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
